// File: rtl/hopfield_io_bridge_if.sv
// Stream-in / stream-out and network-side signals of the Hopfield host bridge.
// The bridge takes the slave view; the host fabric and network model take the master view.
interface hopfield_io_bridge_if #(
    parameter int WIDTH = 5
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] b0_out;
    logic [WIDTH-1:0] b1_out;
    logic [WIDTH-1:0] b2_out;
    logic [WIDTH-1:0] b3_out;
    logic             start;
    logic             net_done;
    logic [WIDTH-1:0] net_result;
    logic [1:0]       res_sel;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             timeout;

    modport slave (
        input  in_data, in_valid, net_done, net_result, out_ready,
        output in_ready, b0_out, b1_out, b2_out, b3_out, start,
               res_sel, out_data, out_valid, busy, timeout
    );

    modport master (
        output in_data, in_valid, net_done, net_result, out_ready,
        input  in_ready, b0_out, b1_out, b2_out, b3_out, start,
               res_sel, out_data, out_valid, busy, timeout
    );
endinterface

// File: rtl/hopfield_io_bridge.sv
// Packs four stream words into the network pattern bus, pulses start, then streams the recalled pattern back.
// Optional WAIT timeout enabled by HOPFIELD_IO_BRIDGE_TIMEOUT_EN.
module hopfield_io_bridge #(
    parameter int WIDTH   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    hopfield_io_bridge_if.slave  bus
);
    typedef enum logic [2:0] {LOAD, START, WAIT, READ, SEND} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] s0, s1, s2;
    logic [WIDTH-1:0] b0, b1, b2, b3;
    logic [WIDTH-1:0] out_q;
    logic [1:0]       widx, k, sel;
    logic             done_q;
    logic             in_fire, out_fire, done_rise;
    logic             to_hit, to_flag;

    assign in_fire   = (state == LOAD) & bus.in_valid;
    assign out_fire  = (state == SEND) & bus.out_ready;
    assign done_rise = bus.net_done & ~done_q;

`ifdef HOPFIELD_IO_BRIDGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;

    // Zero on the first WAIT cycle, so the exit lands exactly TIMEOUT cycles after entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 wait_cnt <= '0;
        else if (state != WAIT)  wait_cnt <= '0;
        else                     wait_cnt <= wait_cnt + 1'b1;
    end

    assign to_hit = (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      to_flag <= 1'b0;
        else if (state == WAIT && to_hit && !done_rise) to_flag <= 1'b1;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT;
    assign to_hit  = 1'b0;
    assign to_flag = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (in_fire && widx == 2'd3) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (done_rise)   state_nxt = READ;
                     else if (to_hit) state_nxt = LOAD;
            READ:    state_nxt = SEND;
            SEND:    if (out_fire) state_nxt = (k == 2'd3) ? LOAD : READ;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0     <= '0;
            s1     <= '0;
            s2     <= '0;
            b0     <= '0;
            b1     <= '0;
            b2     <= '0;
            b3     <= '0;
            out_q  <= '0;
            widx   <= '0;
            k      <= '0;
            sel    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= bus.net_done;
            // The pattern bus only changes on the fourth word, so it never shows a partial pattern.
            if (in_fire) begin
                case (widx)
                    2'd0:    s0 <= bus.in_data;
                    2'd1:    s1 <= bus.in_data;
                    2'd2:    s2 <= bus.in_data;
                    default: begin
                        b0 <= s0;
                        b1 <= s1;
                        b2 <= s2;
                        b3 <= bus.in_data;
                    end
                endcase
                widx <= widx + 2'd1;
            end
            if (state == START) begin
                k   <= '0;
                sel <= '0;
            end
            if (state == READ) out_q <= bus.net_result;
            if (out_fire && k != 2'd3) begin
                k   <= k + 2'd1;
                sel <= k + 2'd1;
            end
        end
    end

    assign bus.in_ready  = (state == LOAD);
    assign bus.busy      = (state != LOAD);
    assign bus.start     = (state == START);
    assign bus.out_valid = (state == SEND);
    assign bus.out_data  = out_q;
    assign bus.res_sel   = sel;
    assign bus.b0_out    = b0;
    assign bus.b1_out    = b1;
    assign bus.b2_out    = b2;
    assign bus.b3_out    = b3;
    assign bus.timeout   = to_flag;
endmodule
